multi_fault_supervisor: RTL and testbench
=========================================

MULTI_FAULT_SUPERVISOR -- requirements
Module: multi_fault_supervisor

Interface
REQ-001 Parameter NUM_CH, default 4: number of fault input channels, range 2..16.
REQ-002 Parameter DEB_CYC, default 3: consecutive qualified cycles before a channel is persistent, range 1..255.
REQ-003 Parameter WARN2FAULT, default 8: persistent-dwell cycles in WARNING before FAULT, range 1..255.
REQ-004 Parameter FAULT2SD, default 16: persistent-dwell cycles in FAULT before SHUTDOWN, range 1..255.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 fault_in  in  NUM_CH  raw per-channel fault requests, bit i = channel i.
REQ-008 mask  in  NUM_CH  per-channel mask; 1 = channel ignored.
REQ-009 clear_warning  in  1  operator clear for WARNING/FAULT de-escalation.
REQ-010 clear_shutdown  in  1  operator clear for SHUTDOWN exit.
REQ-011 state  out  2  current state: 0 NORMAL, 1 WARNING, 2 FAULT, 3 SHUTDOWN.
REQ-012 warn, fault, shutdown  out  1 each  one-hot decode of state (all 0 in NORMAL).
REQ-013 persist_vec  out  NUM_CH  per-channel persistent flags.
REQ-014 active_fault_id  out  $clog2(NUM_CH)  index of lowest-numbered persistent channel; 0 when none.
REQ-015 active_valid  out  1  1 when any persistent_vec bit is set.

Function
REQ-016 Qualified request q[i] = fault_in[i] AND NOT mask[i]; all outputs registered.
REQ-017 Per-channel debounce counter increments each cycle q[i]=1, saturates at DEB_CYC, clears to 0 the cycle q[i]=0 (including on mask assertion mid-count).
REQ-018 persist_vec[i]=1 exactly while its counter equals DEB_CYC; q[i] high from edge 0 gives persist at edge DEB_CYC, pulses shorter than DEB_CYC cycles never set it.
REQ-019 Shared dwell counter increments each cycle any persist bit is set, clears when none set, clears on every state change.
REQ-020 NORMAL -> WARNING on the edge after any persist bit becomes set.
REQ-021 WARNING -> FAULT when dwell reaches WARN2FAULT; WARNING -> NORMAL when clear_warning=1 and no persist bit set; clear_warning with persist set is ignored.
REQ-022 FAULT -> SHUTDOWN when dwell reaches FAULT2SD; FAULT -> WARNING when clear_warning=1 and no persist bit set.
REQ-023 SHUTDOWN sticky; exits to NORMAL only when clear_shutdown=1 and no persist bit set; clear_warning ignored in SHUTDOWN.
REQ-024 Simultaneous escalation threshold and clear: escalation wins only if persist set (clear then ineffective), so no conflict arises; simultaneous multi-channel faults report lowest index.
REQ-025 active_fault_id/active_valid track persist_vec combinationally-from-registers, same cycle as persist_vec.

Reset
REQ-026 rst=1 at an edge forces state=NORMAL, all debounce and dwell counters 0, persist_vec=0, active_fault_id=0, active_valid=0, warn=fault=shutdown=0, from any state including mid-debounce and SHUTDOWN.

Configuration
REQ-027 Macro FAULT_HISTORY_EN defined: adds output history  out  NUM_CH, sticky bit per channel set when persist_vec[i] rises, cleared only by rst or clear_shutdown accepted in SHUTDOWN.
REQ-028 FAULT_HISTORY_EN undefined: history port and its registers absent; all other behaviour identical.

Structure
REQ-029 Package fault_pkg holds the 2-bit state encoding constants (NORMAL, WARNING, FAULT, SHUTDOWN) shared with other fault blocks.
REQ-030 Sub-module fault_debounce (one channel: counter + persist flag, parameter DEB_CYC) instantiated NUM_CH times via generate.

Verification (NUM_CH=4, DEB_CYC=3, WARN2FAULT=8, FAULT2SD=16)
REQ-031 fault_in[2] high 2 cycles -> persist_vec stays 0, state stays NORMAL.
REQ-032 fault_in[1] held, then released, then clear_warning pulse -> persist at edge 3, WARNING at edge 4, FAULT 8 cycles later, then WARNING, then NORMAL after further clear_warning pulse.
REQ-033 fault_in[3] held 40 cycles -> WARNING, FAULT, SHUTDOWN; release + clear_warning -> stays SHUTDOWN; clear_shutdown -> NORMAL.
REQ-034 mask[0]=1, fault_in[0] held 50 cycles -> no state change; fault_in[0] and fault_in[3] together unmasked -> active_fault_id=0, active_valid=1.
REQ-035 rst pulsed while in FAULT -> next cycle state=0, all counters/outputs 0; with FAULT_HISTORY_EN, history=0.

Source files
------------

// File: rtl/fault_pkg.sv
// ----------------------------------------------------------------------------
// fault_pkg
//   Shared definitions for the fault-handling blocks.
//
//   Contents:
//     state_t  - 2-bit supervisor state encoding, shared with other fault
//                blocks: NORMAL=0, WARNING=1, FAULT=2, SHUTDOWN=3.
//     DWELL_W  - width of the shared persistent-dwell counter; wide enough for
//                the largest escalation threshold (255).
// ----------------------------------------------------------------------------
package fault_pkg;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        WARNING  = 2'd1,
        FAULT    = 2'd2,
        SHUTDOWN = 2'd3
    } state_t;

    localparam int DWELL_W = 8;

endpackage : fault_pkg

// File: rtl/fault_debounce.sv
// ----------------------------------------------------------------------------
// fault_debounce
//   One fault channel: counts consecutive cycles of a qualified request and
//   raises a persistent flag while the count sits at DEB_CYC. A single low
//   cycle on the request drops the count back to zero.
//
//   Parameters:
//     DEB_CYC  consecutive qualified cycles before the channel is persistent
//              (1..255).
//
//   Ports:
//     clk      in   rising-edge clock
//     rst      in   synchronous active-high reset
//     q        in   qualified request (raw fault AND NOT mask)
//     persist  out  registered persistent flag, high while count == DEB_CYC
// ----------------------------------------------------------------------------
module fault_debounce #(
    parameter int DEB_CYC = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic q,
    output logic persist
);

    localparam int CW = $clog2(DEB_CYC + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_next = '0;
        if (q) begin
            cnt_next = (cnt == CW'(DEB_CYC)) ? cnt : cnt + 1'b1;
        end
    end

    // The flag is registered from the next count, so it rises on the same
    // edge the counter reaches DEB_CYC rather than one cycle later.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            persist <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            persist <= (cnt_next == CW'(DEB_CYC));
        end
    end

endmodule : fault_debounce

// File: rtl/multi_fault_supervisor.sv
// ----------------------------------------------------------------------------
// multi_fault_supervisor
//   Debounces NUM_CH fault channels and escalates through
//   NORMAL -> WARNING -> FAULT -> SHUTDOWN while any channel stays persistent.
//   Operator clears de-escalate only once no channel is persistent; SHUTDOWN
//   is left only through clear_shutdown.
//
//   Optional feature (macro FAULT_HISTORY_EN):
//     adds output `history`, a sticky per-channel record of channels that have
//     been persistent, cleared by rst or by an accepted SHUTDOWN clear.
//
//   Parameters:
//     NUM_CH      number of fault channels (2..16)
//     DEB_CYC     debounce length in cycles (1..255)
//     WARN2FAULT  persistent-dwell cycles in WARNING before FAULT (1..255)
//     FAULT2SD    persistent-dwell cycles in FAULT before SHUTDOWN (1..255)
//
//   Ports:
//     clk              in   rising-edge clock
//     rst              in   synchronous active-high reset
//     fault_in         in   raw fault requests, bit i = channel i
//     mask             in   1 = channel ignored
//     clear_warning    in   clear for WARNING -> NORMAL and FAULT -> WARNING
//     clear_shutdown   in   clear for SHUTDOWN -> NORMAL
//     state            out  current state (fault_pkg::state_t encoding)
//     warn/fault/shutdown out one-hot decode of state, all 0 in NORMAL
//     persist_vec      out  per-channel persistent flags
//     active_fault_id  out  lowest persistent channel index, 0 when none
//     active_valid     out  any channel persistent
//     history          out  (FAULT_HISTORY_EN only) sticky persistent record
// ----------------------------------------------------------------------------
module multi_fault_supervisor
    import fault_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DEB_CYC    = 3,
    parameter int WARN2FAULT = 8,
    parameter int FAULT2SD   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         fault_in,
    input  logic [NUM_CH-1:0]         mask,
    input  logic                      clear_warning,
    input  logic                      clear_shutdown,
    output logic [1:0]                state,
    output logic                      warn,
    output logic                      fault,
    output logic                      shutdown,
    output logic [NUM_CH-1:0]         persist_vec,
    output logic [$clog2(NUM_CH)-1:0] active_fault_id,
`ifdef FAULT_HISTORY_EN
    output logic [NUM_CH-1:0]         history,
`endif
    output logic                      active_valid
);

    localparam int ID_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]  qual;
    logic               any_persist;
    state_t             cur_state;
    state_t             next_state;
    logic [DWELL_W-1:0] dwell;
    logic               warn_hit;
    logic               sd_hit;

    assign qual = fault_in & ~mask;

    // ------------------------------------------------------------------
    // Per-channel debounce
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        fault_debounce #(
            .DEB_CYC (DEB_CYC)
        ) u_deb (
            .clk     (clk),
            .rst     (rst),
            .q       (qual[g]),
            .persist (persist_vec[g])
        );
    end

    assign any_persist  = |persist_vec;
    assign active_valid = any_persist;

    // Lowest index wins: scan from the top so the last match is the lowest.
    always_comb begin
        active_fault_id = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (persist_vec[i]) begin
                active_fault_id = ID_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Escalation FSM
    // ------------------------------------------------------------------
    // The threshold is hit on the edge where the dwell count would reach it,
    // so WARN2FAULT persistent cycles in WARNING land exactly WARN2FAULT edges
    // after entry. Escalation needs a persistent channel and every clear needs
    // none, so the two can never compete on the same edge.
    assign warn_hit = any_persist && (dwell == DWELL_W'(WARN2FAULT - 1));
    assign sd_hit   = any_persist && (dwell == DWELL_W'(FAULT2SD - 1));

    always_comb begin
        next_state = cur_state;
        unique case (cur_state)
            NORMAL: begin
                if (any_persist) begin
                    next_state = WARNING;
                end
            end
            WARNING: begin
                if (warn_hit) begin
                    next_state = FAULT;
                end else if (clear_warning && !any_persist) begin
                    next_state = NORMAL;
                end
            end
            FAULT: begin
                if (sd_hit) begin
                    next_state = SHUTDOWN;
                end else if (clear_warning && !any_persist) begin
                    next_state = WARNING;
                end
            end
            SHUTDOWN: begin
                if (clear_shutdown && !any_persist) begin
                    next_state = NORMAL;
                end
            end
            default: next_state = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= NORMAL;
            dwell     <= '0;
            warn      <= 1'b0;
            fault     <= 1'b0;
            shutdown  <= 1'b0;
        end else begin
            cur_state <= next_state;
            warn      <= (next_state == WARNING);
            fault     <= (next_state == FAULT);
            shutdown  <= (next_state == SHUTDOWN);
            // Dwell restarts on any state change or once nothing is persistent;
            // it saturates so a long SHUTDOWN stay cannot wrap it.
            if ((next_state != cur_state) || !any_persist) begin
                dwell <= '0;
            end else if (dwell != '1) begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    assign state = cur_state;

`ifdef FAULT_HISTORY_EN
    // ------------------------------------------------------------------
    // Sticky history. The live persist flags are OR-ed onto the output so a
    // channel shows up on the same edge its persist flag rises.
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] history_q;
    logic              sd_clear;

    assign sd_clear = (cur_state == SHUTDOWN) && clear_shutdown && !any_persist;

    always_ff @(posedge clk) begin
        if (rst) begin
            history_q <= '0;
        end else if (sd_clear) begin
            history_q <= '0;
        end else begin
            history_q <= history_q | persist_vec;
        end
    end

    assign history = history_q | persist_vec;
`endif

endmodule : multi_fault_supervisor

// File: tb/tb_multi_fault_supervisor.sv
// ----------------------------------------------------------------------------
// tb_multi_fault_supervisor
//   Directed bench for multi_fault_supervisor (NUM_CH=4, DEB_CYC=3,
//   WARN2FAULT=8, FAULT2SD=16). A behavioural model tracks run lengths of each
//   qualified request and persistent-cycle counts per state; every negedge the
//   DUT outputs are compared to it. Literal expectations at chosen edges pin
//   the model to the hand-derived timeline.
// ----------------------------------------------------------------------------
module tb_multi_fault_supervisor;

    localparam int NUM_CH     = 4;
    localparam int DEB_CYC    = 3;
    localparam int WARN2FAULT = 8;
    localparam int FAULT2SD   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] fault_in;
    logic [NUM_CH-1:0] mask;
    logic              clear_warning;
    logic              clear_shutdown;
    logic [1:0]        state;
    logic              warn;
    logic              fault;
    logic              shutdown;
    logic [NUM_CH-1:0] persist_vec;
    logic [1:0]        active_fault_id;
    logic              active_valid;
`ifdef FAULT_HISTORY_EN
    logic [NUM_CH-1:0] history;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multi_fault_supervisor #(
        .NUM_CH     (NUM_CH),
        .DEB_CYC    (DEB_CYC),
        .WARN2FAULT (WARN2FAULT),
        .FAULT2SD   (FAULT2SD)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fault_in        (fault_in),
        .mask            (mask),
        .clear_warning   (clear_warning),
        .clear_shutdown  (clear_shutdown),
        .state           (state),
        .warn            (warn),
        .fault           (fault),
        .shutdown        (shutdown),
        .persist_vec     (persist_vec),
        .active_fault_id (active_fault_id),
`ifdef FAULT_HISTORY_EN
        .history         (history),
`endif
        .active_valid    (active_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int              run_len [NUM_CH];
    logic [NUM_CH-1:0] m_pv;
    int              m_state;
    int              m_in_state;   // persistent cycles spent in current state
    logic [NUM_CH-1:0] m_hist;
    bit              m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) run_len[i] = 0;
            m_pv       = '0;
            m_state    = 0;
            m_in_state = 0;
            m_hist     = '0;
            m_valid    = 1'b1;
        end else begin
            bit any_p;
            int ns;
            bit sd_clr;
            any_p  = (m_pv != 0);
            ns     = m_state;
            sd_clr = 1'b0;
            case (m_state)
                0: if (any_p) ns = 1;
                1: if (any_p && m_in_state + 1 >= WARN2FAULT) ns = 2;
                   else if (clear_warning && !any_p) ns = 0;
                2: if (any_p && m_in_state + 1 >= FAULT2SD) ns = 3;
                   else if (clear_warning && !any_p) ns = 1;
                default: if (clear_shutdown && !any_p) begin ns = 0; sd_clr = 1'b1; end
            endcase
            if (ns != m_state || !any_p) m_in_state = 0;
            else                         m_in_state = m_in_state + 1;
            m_state = ns;
            for (int i = 0; i < NUM_CH; i++) begin
                run_len[i] = (fault_in[i] && !mask[i]) ? run_len[i] + 1 : 0;
                m_pv[i]    = (run_len[i] >= DEB_CYC);
            end
            if (sd_clr) m_hist = '0;
            m_hist = m_hist | m_pv;
        end
    end

    function automatic int model_id(input logic [NUM_CH-1:0] pv);
        for (int i = 0; i < NUM_CH; i++) if (pv[i]) return i;
        return 0;
    endfunction

    // Compare process: every negedge once the model has seen a reset.
    always @(negedge clk) begin
        if (m_valid) begin
            check("state",       32'(state),           32'(m_state));
            check("warn",        32'(warn),            32'(m_state == 1));
            check("fault",       32'(fault),           32'(m_state == 2));
            check("shutdown",    32'(shutdown),        32'(m_state == 3));
            check("persist_vec", 32'(persist_vec),     32'(m_pv));
            check("active_id",   32'(active_fault_id), 32'(model_id(m_pv)));
            check("active_vld",  32'(active_valid),    32'(m_pv != 0));
`ifdef FAULT_HISTORY_EN
            check("history",     32'(history),         32'(m_hist));
`endif
        end
    end

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear_warning();
        clear_warning = 1'b1;
        step(1);
        clear_warning = 1'b0;
    endtask

    task automatic pulse_clear_shutdown();
        clear_shutdown = 1'b1;
        step(1);
        clear_shutdown = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations. "edge k" is counted from
    // the edge just before the inputs are changed.
    // ------------------------------------------------------------------
    initial begin
        rst            = 1'b1;
        fault_in       = '0;
        mask           = '0;
        clear_warning  = 1'b0;
        clear_shutdown = 1'b0;
        step(3);
        rst = 1'b0;
        check("lit_reset_state",   32'(state),        32'd0);
        check("lit_reset_persist", 32'(persist_vec),  32'd0);
        check("lit_reset_valid",   32'(active_valid), 32'd0);

        // Short pulse on channel 2: never becomes persistent.
        fault_in = 4'b0100;
        step(2);
        fault_in = '0;
        step(5);
        check("lit_short_persist", 32'(persist_vec), 32'd0);
        check("lit_short_state",   32'(state),       32'd0);

        // Channel 1 held: persist at edge 3, WARNING at edge 4, FAULT at 12.
        fault_in = 4'b0010;
        step(2);
        check("lit_ch1_e2_persist", 32'(persist_vec), 32'd0);
        step(1);
        check("lit_ch1_e3_persist", 32'(persist_vec),     32'b0010);
        check("lit_ch1_e3_id",      32'(active_fault_id), 32'd1);
        check("lit_ch1_e3_state",   32'(state),           32'd0);
        step(1);
        check("lit_ch1_e4_state",   32'(state), 32'd1);
        pulse_clear_warning();              // ignored: channel still persistent
        check("lit_ch1_e5_state",   32'(state), 32'd1);
        step(6);
        check("lit_ch1_e11_state",  32'(state), 32'd1);
        step(1);
        check("lit_ch1_e12_state",  32'(state), 32'd2);
        check("lit_ch1_e12_fault",  32'(fault), 32'd1);
        fault_in = '0;
        step(2);
        check("lit_ch1_released",   32'(persist_vec), 32'd0);
        pulse_clear_warning();
        check("lit_ch1_to_warn",    32'(state), 32'd1);
        step(2);
        check("lit_ch1_stay_warn",  32'(state), 32'd1);
        pulse_clear_warning();
        check("lit_ch1_to_normal",  32'(state), 32'd0);
        step(2);

        // Channel 3 held 40 cycles: WARNING 4, FAULT 12, SHUTDOWN 28.
        fault_in = 4'b1000;
        step(4);
        check("lit_ch3_e4_state",  32'(state), 32'd1);
        step(8);
        check("lit_ch3_e12_state", 32'(state), 32'd2);
        step(15);
        check("lit_ch3_e27_state", 32'(state), 32'd2);
        step(1);
        check("lit_ch3_e28_state", 32'(state),    32'd3);
        check("lit_ch3_e28_sd",    32'(shutdown), 32'd1);
        step(12);
        fault_in = '0;
        step(2);
        pulse_clear_warning();
        check("lit_ch3_sd_sticky", 32'(state), 32'd3);
        pulse_clear_shutdown();
        check("lit_ch3_sd_exit",   32'(state), 32'd0);
        step(2);

        // Masked channel 0 held 50 cycles: no effect.
        mask     = 4'b0001;
        fault_in = 4'b0001;
        step(50);
        check("lit_mask_state",   32'(state),       32'd0);
        check("lit_mask_persist", 32'(persist_vec), 32'd0);

        // Channels 0 and 3 together, unmasked: lowest index reported.
        mask     = '0;
        fault_in = 4'b1001;
        step(3);
        check("lit_multi_persist", 32'(persist_vec),     32'b1001);
        check("lit_multi_id",      32'(active_fault_id), 32'd0);
        check("lit_multi_valid",   32'(active_valid),    32'd1);
        step(9);
        check("lit_multi_fault",   32'(state), 32'd2);

        // Reset while in FAULT.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("lit_rst_state",   32'(state),           32'd0);
        check("lit_rst_flags",   32'({warn, fault, shutdown}), 32'd0);
        check("lit_rst_persist", 32'(persist_vec),     32'd0);
        check("lit_rst_id",      32'(active_fault_id), 32'd0);
        check("lit_rst_valid",   32'(active_valid),    32'd0);
`ifdef FAULT_HISTORY_EN
        check("lit_rst_history", 32'(history),         32'd0);
`endif
        fault_in = '0;
        step(2);

        // Mask asserted mid-count restarts the debounce.
        fault_in = 4'b0100;
        step(2);
        mask = 4'b0100;
        step(1);
        mask = '0;
        step(2);
        check("lit_midmask_e5", 32'(persist_vec), 32'd0);
        step(1);
        check("lit_midmask_e6", 32'(persist_vec), 32'b0100);
        check("lit_midmask_id", 32'(active_fault_id), 32'd2);
        step(1);
        check("lit_midmask_warn", 32'(state), 32'd1);
        fault_in = '0;
        step(2);
        pulse_clear_warning();
        check("lit_midmask_normal", 32'(state), 32'd0);

        // Reset mid-debounce, then let the channel qualify afresh.
        fault_in = 4'b0001;
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);
        check("lit_rstdeb_e2", 32'(persist_vec), 32'd0);
        step(1);
        check("lit_rstdeb_e3", 32'(persist_vec), 32'b0001);
        fault_in = '0;
        step(3);

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_multi_fault_supervisor
